// File: rtl/qif_chan_arb.sv
// qif_chan_arb: round-robin arbiter sharing one QIf handshake channel among
// NREQ requesters. The winning requester owns the channel for the whole
// transaction (request, grant, response, response accept). A response
// watchdog raises a sticky timeout flag when QIf holds off a response too long.
module qif_chan_arb #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int TMO  = 255,
  localparam int OW  = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NREQ-1:0]    s_vld,
  input  logic [NREQ-1:0]    s_wait,
  input  logic [NREQ*DW-1:0] s_dat,
  output logic [NREQ-1:0]    s_gnt,
  output logic [NREQ-1:0]    s_rvld,
  output logic [NREQ-1:0]    s_err,
  output logic [DW-1:0]      s_rdat,
  input  logic [NREQ-1:0]    s_rgnt,
  output logic               m_vld,
  output logic               m_wait,
  output logic [DW-1:0]      m_dat,
  input  logic               m_gnt,
  input  logic               m_rvld,
  input  logic               m_err,
  input  logic [DW-1:0]      m_rdat,
  output logic               m_rgnt,
  output logic               busy,
  output logic [OW-1:0]      owner,
  output logic               tmo,
  input  logic               tmo_clr
);

  localparam int OW1 = OW + 1;
  localparam int CW  = (TMO < 1) ? 1 : $clog2(TMO + 1);
  localparam logic [CW-1:0]  TMO_C  = CW'(TMO);
  localparam logic [OW-1:0]  LAST_C = OW'(NREQ - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RSP  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [OW-1:0] ptr_q, ptr_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;
  logic          req_acc_s;
  logic          rsp_done_s;
  logic          tmo_set_s;

  // First requester at or after base, wrapping modulo NREQ; base if none.
  function automatic logic [OW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                            input logic [OW-1:0]   base);
    logic [OW-1:0] res;
    logic [OW1-1:0] sum;
    logic hit;
    res = base;
    hit = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, base} + OW1'(k);
      sum = (sum >= OW1'(NREQ)) ? (sum - OW1'(NREQ)) : sum;
      if (!hit && req[sum[OW-1:0]]) begin
        res = sum[OW-1:0];
        hit = 1'b1;
      end
    end
    return res;
  endfunction

  assign req_acc_s  = s_vld[owner_q] & m_gnt;
  assign rsp_done_s = m_rvld & s_rgnt[owner_q];

  // Next-state, owner and rotation pointer selection.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (|s_vld) begin
          owner_d = rr_pick(s_vld, ptr_q);
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (req_acc_s) begin
          state_d = ST_RSP;
        end else if (!s_vld[owner_q]) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_RSP: begin
        if (rsp_done_s) begin
          state_d = ST_IDLE;
          ptr_d   = (owner_q == LAST_C) ? '0 : (owner_q + OW'(1));
        end else begin
          state_d = ST_RSP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Watchdog: restart on entry to RSP, count stalled RSP cycles up to TMO.
  always_comb begin
    cnt_d     = cnt_q;
    tmo_set_s = 1'b0;
    if (state_q == ST_REQ && req_acc_s) begin
      cnt_d = '0;
    end else if (state_q == ST_RSP && !m_rvld && cnt_q != TMO_C) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
    if (TMO != 0 && state_q == ST_RSP && !m_rvld && cnt_d == TMO_C) begin
      tmo_set_s = 1'b1;
    end else begin
      tmo_set_s = 1'b0;
    end
    if (tmo_set_s) begin
      tmo_d = 1'b1;
    end else if (tmo_clr) begin
      tmo_d = 1'b0;
    end else begin
      tmo_d = tmo_q;
    end
  end

  // State, pointer, owner and watchdog registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // Route handshake to/from the owner only; everyone else sees zeros.
  always_comb begin
    s_gnt  = '0;
    s_rvld = '0;
    s_err  = '0;
    m_vld  = 1'b0;
    m_wait = 1'b0;
    m_rgnt = 1'b0;
    case (state_q)
      ST_REQ: begin
        m_vld          = s_vld[owner_q];
        m_wait         = s_wait[owner_q];
        s_gnt[owner_q] = m_gnt;
      end
      ST_RSP: begin
        s_rvld[owner_q] = m_rvld;
        s_err[owner_q]  = m_err;
        m_rgnt          = s_rgnt[owner_q] & m_rvld;
      end
      default: begin
        m_vld = 1'b0;
      end
    endcase
  end

  assign m_dat  = s_dat[owner_q*DW +: DW];
  assign s_rdat = m_rdat;
  assign busy   = (state_q != ST_IDLE);
  assign owner  = owner_q;
  assign tmo    = tmo_q;

endmodule

// File: tb/tb_qif_chan_arb.sv
// Directed table-driven bench for qif_chan_arb (NREQ=4, DW=8, TMO=8).
// Each vector holds the inputs for one cycle and the outputs expected in that
// cycle; the clock then advances one edge.
module tb_qif_chan_arb;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  s_vld, s_wait, s_rgnt;
  logic [31:0] s_dat;
  logic [3:0]  s_gnt, s_rvld, s_err;
  logic [7:0]  s_rdat, m_dat, m_rdat;
  logic        m_vld, m_wait, m_gnt, m_rvld, m_err, m_rgnt;
  logic        busy, tmo, tmo_clr;
  logic [1:0]  owner;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] vld, wt, rg;
    logic       mg, mr, me;
    logic [7:0] md;
    logic       clr;
    logic [34:0] exp_o;
  } vec_t;

  vec_t vecs[$];

  qif_chan_arb #(.NREQ(4), .DW(8), .TMO(8)) dut (
    .clk(clk), .rstn(rstn),
    .s_vld(s_vld), .s_wait(s_wait), .s_dat(s_dat),
    .s_gnt(s_gnt), .s_rvld(s_rvld), .s_err(s_err), .s_rdat(s_rdat),
    .s_rgnt(s_rgnt),
    .m_vld(m_vld), .m_wait(m_wait), .m_dat(m_dat), .m_gnt(m_gnt),
    .m_rvld(m_rvld), .m_err(m_err), .m_rdat(m_rdat), .m_rgnt(m_rgnt),
    .busy(busy), .owner(owner), .tmo(tmo), .tmo_clr(tmo_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [34:0] pack_exp(
      input logic [3:0] eg, er, ee, input logic [7:0] erd,
      input logic emv, emw, input logic [7:0] emd,
      input logic emr, eb, input logic [1:0] eo, input logic et);
    return {eg, er, ee, erd, emv, emw, emd, emr, eb, eo, et};
  endfunction

  // s_rdat is a plain passthrough of m_rdat, so its expectation is the driven md.
  function automatic void add(
      input logic [3:0] vld, wt, rg, input logic mg, mr, me,
      input logic [7:0] md, input logic clr,
      input logic [3:0] eg, er, ee, input logic emv, emw,
      input logic [7:0] emd, input logic emr, eb,
      input logic [1:0] eo, input logic et);
    vec_t v;
    v.vld = vld; v.wt = wt; v.rg = rg;
    v.mg = mg; v.mr = mr; v.me = me; v.md = md; v.clr = clr;
    v.exp_o = pack_exp(eg, er, ee, md, emv, emw, emd, emr, eb, eo, et);
    vecs.push_back(v);
  endfunction

  function automatic logic [34:0] act_o();
    return {s_gnt, s_rvld, s_err, s_rdat, m_vld, m_wait, m_dat,
            m_rgnt, busy, owner, tmo};
  endfunction

  task automatic check(input string name, input logic [34:0] got,
                       input logic [34:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  initial begin
    // requester payloads: 0=11 1=22 2=A5 3=44
    s_dat = 32'h44A5_2211;
    rstn = 1'b0;
    s_vld = 4'b0; s_wait = 4'b0; s_rgnt = 4'b0;
    m_gnt = 1'b0; m_rvld = 1'b0; m_err = 1'b0; m_rdat = 8'h5A; tmo_clr = 1'b0;

    //  vld    wt     rg     mg    mr    me    md     clr | eg     er     ee     mv    mw    mdat   mrg   bsy   own   tmo
    // single requester 2: grant, response, ptr -> 3
    add(4'h4, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 2'd0, 1'b0);
    add(4'h4, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'h4, 4'h0, 4'h0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 2'd2, 1'b0);
    add(4'h0, 4'h0, 4'h4, 1'b0, 1'b1, 1'b0, 8'h77, 1'b0, 4'h0, 4'h4, 4'h0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 2'd2, 1'b0);
    // wrap from ptr 3 to requester 0, QIf stalls grant, error response
    add(4'h3, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 2'd2, 1'b0);
    add(4'h3, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b1, 2'd0, 1'b0);
    add(4'h3, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'h1, 4'h0, 4'h0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b1, 2'd0, 1'b0);
    add(4'h2, 4'h0, 4'h1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 4'h0, 4'h1, 4'h1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1, 2'd0, 1'b0);
    // wait-mode read by requester 1, QIf holds off then returns 3C
    add(4'h2, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 2'd0, 1'b0);
    add(4'h2, 4'h2, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'h2, 4'h0, 4'h0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 2'd1, 1'b0);
    add(4'h0, 4'h0, 4'h2, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 2'd1, 1'b0);
    add(4'h8, 4'h0, 4'h2, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 2'd1, 1'b0);
    add(4'h8, 4'h0, 4'h2, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 4'h0, 4'h2, 4'h0, 1'b0, 1'b0, 8'h22, 1'b1, 1'b1, 2'd1, 1'b0);
    // requester 3 withdraws in REQ; ptr stays 2 so requester 2 wins next
    add(4'h8, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 2'd1, 1'b0);
    add(4'h8, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 8'h44, 1'b0, 1'b1, 2'd3, 1'b0);
    add(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h44, 1'b0, 1'b1, 2'd3, 1'b0);
    add(4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h44, 1'b0, 1'b0, 2'd3, 1'b0);
    add(4'hF, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'h4, 4'h0, 4'h0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 2'd2, 1'b0);
    // watchdog: 8 stalled RSP cycles; clear in the setting cycle loses
    for (int i = 0; i < 7; i++)
      add(4'hF, 4'h0, 4'h4, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 2'd2, 1'b0);
    add(4'hF, 4'h0, 4'h4, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 2'd2, 1'b0);
    add(4'hF, 4'h0, 4'h4, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 2'd2, 1'b1);
    add(4'hF, 4'h0, 4'h4, 1'b0, 1'b1, 1'b0, 8'h99, 1'b0, 4'h0, 4'h4, 4'h0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 2'd2, 1'b1);
    add(4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 2'd2, 1'b1);
    // all requesting: rotation continues 3, 0, 1
    add(4'hF, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'h8, 4'h0, 4'h0, 1'b1, 1'b0, 8'h44, 1'b0, 1'b1, 2'd3, 1'b0);
    add(4'hF, 4'h0, 4'h8, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 4'h0, 4'h8, 4'h0, 1'b0, 1'b0, 8'h44, 1'b1, 1'b1, 2'd3, 1'b0);
    add(4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h44, 1'b0, 1'b0, 2'd3, 1'b0);
    add(4'hF, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'h1, 4'h0, 4'h0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b1, 2'd0, 1'b0);
    add(4'hF, 4'h0, 4'h1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 4'h0, 4'h1, 4'h0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1, 2'd0, 1'b0);
    add(4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 2'd0, 1'b0);
    add(4'hF, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'h2, 4'h0, 4'h0, 1'b1, 1'b0, 8'h22, 1'b0, 1'b1, 2'd1, 1'b0);

    // reset state: outputs zero, m_dat shows requester 0, s_rdat follows m_rdat
    #12;
    check("reset", act_o(),
          pack_exp(4'h0, 4'h0, 4'h0, 8'h5A, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 2'd0, 1'b0));
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      s_vld = vecs[i].vld; s_wait = vecs[i].wt; s_rgnt = vecs[i].rg;
      m_gnt = vecs[i].mg; m_rvld = vecs[i].mr; m_err = vecs[i].me;
      m_rdat = vecs[i].md; tmo_clr = vecs[i].clr;
      #2;
      check($sformatf("vec%0d", i), act_o(), vecs[i].exp_o);
      @(posedge clk);
      #1;
    end

    // requester 1 now in RSP: response visible, then reset mid-transaction
    s_vld = 4'h0; s_rgnt = 4'h0; m_gnt = 1'b0;
    m_rvld = 1'b1; m_err = 1'b1; m_rdat = 8'hC3; tmo_clr = 1'b0;
    #2;
    check("rsp_before_rst", act_o(),
          pack_exp(4'h0, 4'h2, 4'h2, 8'hC3, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 2'd1, 1'b0));
    rstn = 1'b0;
    #1;
    check("async_rst", act_o(),
          pack_exp(4'h0, 4'h0, 4'h0, 8'hC3, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 2'd0, 1'b0));
    @(negedge clk);
    rstn = 1'b1;
    m_rvld = 1'b0; m_err = 1'b0;
    @(posedge clk);
    #1;
    check("idle_after_rst", act_o(),
          pack_exp(4'h0, 4'h0, 4'h0, 8'hC3, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 2'd0, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
